// File: rtl/pb_event_pkg.sv
// rtl/pb_event_pkg.sv - shared states and default push-button timing constants
package pb_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    WAIT2,
    HELD2,
    LONG_HELD
  } pb_event_state_t;

  localparam int PB_LONG_CYCLES_DEF   = 1000;
  localparam int PB_DCLICK_CYCLES_DEF = 300;
  localparam int PB_REPEAT_CYCLES_DEF = 100;

  function automatic int pb_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_event_timer.sv
// rtl/pb_event_timer.sv - clearable saturating cycle counter with terminal-count compare
module pb_event_timer
  import pb_event_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturation only matters in states with no limit (HELD2, LONG_HELD without repeat).
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/pb_event_classifier.sv
// rtl/pb_event_classifier.sv - short/long/double-click push-button event classifier
// Optional auto-repeat in LONG_HELD is enabled by defining PB_AUTOREPEAT_EN.
module pb_event_classifier
  import pb_event_pkg::*;
#(
  parameter int LONG_CYCLES   = PB_LONG_CYCLES_DEF,
  parameter int DCLICK_CYCLES = PB_DCLICK_CYCLES_DEF,
  parameter int REPEAT_CYCLES = PB_REPEAT_CYCLES_DEF,
  parameter int CNT_WIDTH     = $clog2(pb_max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_pulse,
  input  logic released_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic busy
);

  // The entry pulse cycle counts toward the hold/window, so those limits sit one lower.
  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] DCLICK_TC = CNT_WIDTH'(DCLICK_CYCLES - 2);
`ifdef PB_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

  pb_event_state_t      state_q, state_d;
  logic                 clear;
  logic [CNT_WIDTH-1:0] limit;
  logic                 tc;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 dclick_q, dclick_d;
  logic                 repeat_q, repeat_d;
  logic                 busy_q;

  pb_event_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear),
    .limit_i(limit),
    .tc_o   (tc)
  );

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    limit    = '0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;
    repeat_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (pressed_pulse && !released_pulse) begin
          state_d = HELD1;
        end
      end
      HELD1: begin
        limit = LONG_TC;
        if (released_pulse) begin
          state_d = WAIT2;
        end else if (tc) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      WAIT2: begin
        limit = DCLICK_TC;
        if (pressed_pulse && !released_pulse) begin
          dclick_d = 1'b1;
          state_d  = HELD2;
        end else if (tc) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      HELD2: begin
        if (released_pulse) begin
          state_d = IDLE;
        end
      end
      LONG_HELD: begin
        if (released_pulse) begin
          state_d = IDLE;
        end
`ifdef PB_AUTOREPEAT_EN
        else begin
          limit = REPEAT_TC;
          if (tc) begin
            repeat_d = 1'b1;
            clear    = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      dclick_q <= dclick_d;
      repeat_q <= repeat_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dclick_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pb_event_classifier.sv
// tb/tb_pb_event_classifier.sv - directed bench with timestamp-based event model
module tb_pb_event_classifier;

  localparam int L = 20;
  localparam int D = 8;
  localparam int R = 5;
`ifdef PB_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pressed_pulse = 1'b0;
  logic released_pulse = 1'b0;
  logic short_press, long_press, double_click, repeat_pulse, busy;

  int nchk = 0;
  int nfail = 0;
  int gcyc = 0;
  int base = 0;

  pb_event_classifier #(
    .LONG_CYCLES  (L),
    .DCLICK_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .double_click  (double_click),
    .repeat_pulse  (repeat_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  // Model: phase plus the timestamp of its anchoring pulse; events fall at fixed offsets.
  typedef enum {M_IDLE, M_HELD1, M_WAIT2, M_HELD2, M_LONG} mphase_t;
  mphase_t ph = M_IDLE;
  int  t0 = 0;
  bit  mv = 1'b0;
  bit  e_sp, e_lp, e_dc, e_rp, e_busy;

  always @(posedge clk) begin : model
    bit p, r;
    p = pressed_pulse && !released_pulse;
    r = released_pulse;
    e_sp = 0; e_lp = 0; e_dc = 0; e_rp = 0;
    if (rst) begin
      ph = M_IDLE;
      mv = 1'b1;
    end else begin
      case (ph)
        M_IDLE:  if (p) begin ph = M_HELD1; t0 = gcyc; end
        M_HELD1: if (r) begin ph = M_WAIT2; t0 = gcyc; end
                 else if (gcyc == t0 + L - 1) begin e_lp = 1; ph = M_LONG; t0 = gcyc; end
        M_WAIT2: if (p) begin e_dc = 1; ph = M_HELD2; end
                 else if (gcyc == t0 + D - 1) begin e_sp = 1; ph = M_IDLE; end
        M_HELD2: if (r) ph = M_IDLE;
        M_LONG:  if (r) ph = M_IDLE;
                 else if (AUTO && ((gcyc - t0) % R == 0)) e_rp = 1;
        default: ph = M_IDLE;
      endcase
    end
    e_busy = (ph != M_IDLE);
  end

  int q_sp[$], q_lp[$], q_dc[$], q_rp[$], q_bz[$];

  always @(negedge clk) begin
    if (mv) begin
      nchk++;
      if ({short_press, long_press, double_click, repeat_pulse, busy} !==
          {e_sp, e_lp, e_dc, e_rp, e_busy}) begin
        nfail++;
        $display("FAIL cycle_compare k=%0d: sp/lp/dc/rp/busy got %b%b%b%b%b expected %b%b%b%b%b",
                 gcyc - base, short_press, long_press, double_click, repeat_pulse, busy,
                 e_sp, e_lp, e_dc, e_rp, e_busy);
      end
      if (short_press === 1'b1)  q_sp.push_back(gcyc - base);
      if (long_press === 1'b1)   q_lp.push_back(gcyc - base);
      if (double_click === 1'b1) q_dc.push_back(gcyc - base);
      if (repeat_pulse === 1'b1) q_rp.push_back(gcyc - base);
      if (busy === 1'b1)         q_bz.push_back(gcyc - base);
    end
  end

  function automatic logic [2:0] stim(input int id, input int k);
    logic r, p, q;
    r = (k < 2); p = 1'b0; q = 1'b0;
    case (id)
      1: begin p = (k == 10); q = (k == 15); end
      2: begin p = (k == 10 || k == 18); q = (k == 14 || k == 22); end
      3: begin p = (k == 10); q = (k == 50); end
      4: begin p = (k == 10); q = (k == 29); end
      5: begin p = (k == 10 || k == 21); q = (k == 14 || k == 25); end
      6: begin r = r || (k == 12); p = (k == 10 || k == 20); q = (k == 15 || k == 22); end
      7: begin p = (k == 10); q = (k == 10); end
      8: begin p = (k == 10 || k == 13); q = (k == 13); end
      default: ;
    endcase
    return {r, p, q};
  endfunction

  task automatic run_scn(input int id, input int len);
    q_sp.delete(); q_lp.delete(); q_dc.delete(); q_rp.delete(); q_bz.delete();
    base = gcyc;
    for (int k = 0; k < len; k++) begin
      {rst, pressed_pulse, released_pulse} = stim(id, k);
      @(posedge clk); #1;
    end
    {rst, pressed_pulse, released_pulse} = 3'b000;
  endtask

  task automatic chk_q(input string nm, input int act[$], input int n,
                       input int a0 = 0, input int a1 = 0, input int a2 = 0, input int a3 = 0);
    int e[4];
    bit ok;
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    ok = (act.size() == n);
    for (int i = 0; ok && i < n; i++) if (act[i] != e[i]) ok = 0;
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got cycles %p expected %0d cycles starting %0d", nm, act, n, a0);
    end
  endtask

  function automatic int busy_in(input int lo, input int hi);
    int n = 0;
    foreach (q_bz[i]) if (q_bz[i] >= lo && q_bz[i] <= hi) n++;
    return n;
  endfunction

  task automatic chk_v(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    @(posedge clk); #1;

    run_scn(1, 40);
    chk_q("s1_short", q_sp, 1, 23);
    chk_q("s1_long", q_lp, 0);
    chk_q("s1_dclick", q_dc, 0);

    run_scn(2, 40);
    chk_q("s2_dclick", q_dc, 1, 19);
    chk_q("s2_short", q_sp, 0);
    chk_v("s2_busy_at22", busy_in(22, 22), 1);
    chk_v("s2_busy_after22", busy_in(23, 39), 0);

    run_scn(3, 70);
    chk_q("s3_long", q_lp, 1, 30);
    if (AUTO) chk_q("s3_repeat", q_rp, 4, 35, 40, 45, 50);
    else      chk_q("s3_repeat_off", q_rp, 0);
    chk_q("s3_short", q_sp, 0);
    chk_v("s3_busy_after_release", busy_in(51, 69), 0);

    run_scn(4, 50);
    chk_q("s4_long_boundary", q_lp, 0);
    chk_q("s4_short_after_wait2", q_sp, 1, 37);

    run_scn(5, 40);
    chk_q("s5_dclick_boundary", q_dc, 1, 22);
    chk_q("s5_short", q_sp, 0);

    run_scn(6, 45);
    chk_v("s6_busy_reset", busy_in(13, 20), 0);
    chk_q("s6_long", q_lp, 0);
    chk_q("s6_short_after_reset", q_sp, 1, 30);

    run_scn(7, 25);
    chk_v("s7_busy_both_idle", q_bz.size(), 0);
    chk_q("s7_short", q_sp, 0);

    run_scn(8, 35);
    chk_q("s8_release_wins", q_sp, 1, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pb_event_classifier.md
# pb_event_classifier

Classifies clean push-button activity into user-level events: short press, long press and double click, with optional auto-repeat while held. It sits directly downstream of the push-button debouncer. It consumes that stage's single-cycle pressed/released pulses and emits single-cycle event pulses to the control FSMs of the lab designs.

## Interface
- LONG_CYCLES, 1000: hold time, in clk cycles from the press pulse, that qualifies a long press; must be ≥ 2.
- DCLICK_CYCLES, 300: window, in clk cycles from the first release pulse, in which a second press forms a double click; must be ≥ 2.
- REPEAT_CYCLES, 100: auto-repeat period in clk cycles; must be ≥ 2; used only with the macro.
- CNT_WIDTH, $clog2(max of the three above)+1: internal counter width.
- clk  in  1  base clock.
- rst  in  1  synchronous, active-high reset.
- pressed_pulse  in  1  one-cycle pulse from the debouncer on press.
- released_pulse  in  1  one-cycle pulse from the debouncer on release.
- short_press  out  1  one-cycle pulse when a single short press is confirmed.
- long_press  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- double_click  out  1  one-cycle pulse on the second press of a double click.
- repeat_pulse  out  1  one-cycle auto-repeat pulse; tied 0 without the macro.
- busy  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, HELD1, WAIT2, HELD2, LONG_HELD. One counter `cnt` is cleared on every state entry and increments each cycle otherwise.
- IDLE:
  - pressed_pulse → HELD1.
  - released_pulse is ignored. This covers a button held through reset.
- HELD1:
  - released_pulse before the limit → WAIT2.
  - cnt == LONG_CYCLES-1 with no release → long_press, then → LONG_HELD.
- WAIT2:
  - pressed_pulse before the limit → double_click, then → HELD2.
  - cnt == DCLICK_CYCLES-1 with no press → short_press, then → IDLE.
- HELD2:
  - released_pulse → IDLE.
  - No long press and no repeat are generated from this state.
- LONG_HELD:
  - released_pulse → IDLE.
  - With the macro: on cnt == REPEAT_CYCLES-1, pulse repeat_pulse and reload cnt to 0.
- Simultaneous pressed_pulse and released_pulse: released_pulse wins in every state; pressed_pulse is dropped.
- In HELD1, release at cnt == LONG_CYCLES-1: release wins, no long_press is emitted, next state is WAIT2.
- In WAIT2, press at cnt == DCLICK_CYCLES-1: press wins, double_click is emitted, no short_press.
- Event outputs are mutually exclusive; at most one is high in any cycle.
- Counter never wraps. It is compared for equality and cleared or reloaded at every limit.

## Timing
- All outputs are registered.
- Reset: state = IDLE, cnt = 0, and short_press, long_press, double_click, repeat_pulse, busy all 0 from the first cycle after rst is sampled high.
- Reset mid-operation aborts any pending event with no output pulse.
- Latencies, with cycle 0 the cycle the input pulse is sampled:
  - busy rises in cycle 1.
  - double_click is high in cycle 1 after the second press.
  - long_press is high in cycle LONG_CYCLES after the press.
  - short_press is high in cycle DCLICK_CYCLES after the release.
  - First repeat_pulse comes REPEAT_CYCLES cycles after long_press, then one every REPEAT_CYCLES cycles.
- busy falls in the cycle after the return to IDLE is decided.

## Configuration
- PB_AUTOREPEAT_EN defined: LONG_HELD generates repeat_pulse as specified above.
- PB_AUTOREPEAT_EN undefined:
  - repeat_pulse is constant 0.
  - LONG_HELD only waits for release.
  - REPEAT_CYCLES is ignored.

## Structure
- Shared package pb_event_pkg holds:
  - the state enum typedef pb_event_state_t;
  - the default cycle constants, so the debouncer and this block share one place for timing.
- One sub-module, pb_event_timer, holds the clearable, reloadable counter and its terminal-count compare.
- The FSM and output registers live in pb_event_classifier.

## Test plan
All scenarios use LONG_CYCLES=20, DCLICK_CYCLES=8, REPEAT_CYCLES=5, macro defined.
- Press at cycle 10, release at 15, no further input → short_press high at cycle 23 only; no other event.
- Press at 10, release at 14, press at 18, release at 22 → double_click high at cycle 19; no short_press; busy low from cycle 23.
- Press at 10, held until 50 → long_press at 30; repeat_pulse at 35, 40, 45, 50; nothing after release.
- Boundary checks:
  - Release at cycle 29 with press at 10 → no long_press, WAIT2 entered.
  - Second press exactly 7 cycles after release → double_click, not short_press.
- rst asserted at cycle 12 during HELD1, with released_pulse at 15 → no events; busy 0 from 13; next normal press classifies correctly.
- Both pulses in the same cycle while in IDLE → no state change, busy stays 0. Rebuild without the macro and repeat the long-hold scenario → repeat_pulse stays 0.
